// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer
// Runs a batch of images through the CNN pipeline. For each image it flushes the
// pipeline, streams IMG_PIXELS pixels from the image RAM, and waits for the
// comparator decision.
// Optional feature: define CNN_SEQ_TIMEOUT_EN to abort a batch when no decision
// arrives within TIMEOUT_CYCLES. Without it, error_o is tied low.

module cnn_frame_sequencer #(
    parameter int IMG_PIXELS     = 784,
    parameter int ADDR_W         = 16,
    parameter int FLUSH_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [7:0]        num_images_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rd_data_i,
    output logic [7:0]        pix_data_o,
    output logic              pix_valid_o,
    output logic              pipe_rst_n_o,
    input  logic              fc_dec_valid_i,
    input  logic [3:0]        fc_decision_i,
    output logic              res_valid_o,
    output logic [3:0]        res_decision_o,
    output logic [7:0]        res_idx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int PIX_W = $clog2(IMG_PIXELS);
    localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_STREAM,
        S_DRAIN,
        S_WAIT_RES,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        num_q, num_d;
    logic [7:0]        img_q, img_d;
    logic [ADDR_W-1:0] img_base_q, img_base_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    logic              rd_valid_q, rd_valid_d;
    logic              res_valid_q, res_valid_d;
    logic [3:0]        res_dec_q, res_dec_d;
    logic [7:0]        res_idx_q, res_idx_d;
    logic              zero_done_q, zero_done_d;
    logic              rd_en;
    logic              pipe_run;

`ifdef CNN_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]   to_q, to_d;
    logic              error_q, error_d;
`endif

    // Next-state, counter updates and per-state output strobes
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        img_d       = img_q;
        img_base_d  = img_base_q;
        pix_d       = pix_q;
        flush_d     = flush_q;
        res_valid_d = 1'b0;
        res_dec_d   = res_dec_q;
        res_idx_d   = res_idx_q;
        zero_done_d = 1'b0;
        rd_en       = 1'b0;
        pipe_run    = 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
        to_d        = to_q;
        error_d     = error_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
`ifdef CNN_SEQ_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                    if (num_images_i == 8'd0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        num_d      = num_images_i;
                        img_d      = 8'd0;
                        img_base_d = base_addr_i;
                        flush_d    = '0;
                        state_d    = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q == FL_W'(FLUSH_CYCLES - 1)) begin
                    pix_d   = '0;
                    state_d = S_STREAM;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            S_STREAM: begin
                pipe_run = 1'b1;
                rd_en    = 1'b1;
                if (pix_q == PIX_W'(IMG_PIXELS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            S_DRAIN: begin
                pipe_run = 1'b1;
`ifdef CNN_SEQ_TIMEOUT_EN
                to_d     = '0;
`endif
                state_d  = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                pipe_run = 1'b1;
                if (fc_dec_valid_i) begin
                    res_valid_d = 1'b1;
                    res_dec_d   = fc_decision_i;
                    res_idx_d   = img_q;
                    if (({1'b0, img_q} + 9'd1) < {1'b0, num_q}) begin
                        img_d      = img_q + 8'd1;
                        img_base_d = img_base_q + ADDR_W'(IMG_PIXELS);
                        flush_d    = '0;
                        state_d    = S_FLUSH;
                    end else begin
                        state_d = S_FIN;
                    end
                end
`ifdef CNN_SEQ_TIMEOUT_EN
                else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register file: synchronous active-low reset returns everything to idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            img_q       <= '0;
            img_base_q  <= '0;
            pix_q       <= '0;
            flush_q     <= '0;
            rd_valid_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_dec_q   <= '0;
            res_idx_q   <= '0;
            zero_done_q <= 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
            to_q        <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            img_q       <= img_d;
            img_base_q  <= img_base_d;
            pix_q       <= pix_d;
            flush_q     <= flush_d;
            rd_valid_q  <= rd_en;
            res_valid_q <= res_valid_d;
            res_dec_q   <= res_dec_d;
            res_idx_q   <= res_idx_d;
            zero_done_q <= zero_done_d;
`ifdef CNN_SEQ_TIMEOUT_EN
            to_q        <= to_d;
            error_q     <= error_d;
`endif
        end
    end

    // The RAM output register supplies the pixel; the valid flag is the read
    // strobe delayed to line up with it, so pixels trail reads by one cycle.
    always_comb begin
        mem_rd_en_o    = rd_en;
        mem_addr_o     = rd_en ? (img_base_q + ADDR_W'(pix_q)) : '0;
        pix_valid_o    = rd_valid_q;
        pix_data_o     = rd_valid_q ? mem_rd_data_i : 8'h00;
        pipe_rst_n_o   = pipe_run;
        res_valid_o    = res_valid_q;
        res_decision_o = res_dec_q;
        res_idx_o      = res_idx_q;
        busy_o         = (state_q != S_IDLE) && (state_q != S_FIN);
        done_o         = (state_q == S_FIN) || zero_done_q;
`ifdef CNN_SEQ_TIMEOUT_EN
        error_o        = error_q;
`else
        error_o        = 1'b0;
`endif
    end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer
// Directed bench for cnn_frame_sequencer with a one-cycle-latency image RAM model.
// The timeout step runs only when CNN_SEQ_TIMEOUT_EN is defined.

module tb_cnn_frame_sequencer;

    logic        clk = 1'b0;
    logic        rstN;
    logic        startI;
    logic [7:0]  numImagesI;
    logic [15:0] baseAddrI;
    logic        memRdEn;
    logic [15:0] memAddr;
    logic [7:0]  memRdData = 8'hEE;
    logic [7:0]  pixData;
    logic        pixValid;
    logic        pipeRstN;
    logic        fcDecValid;
    logic [3:0]  fcDecision;
    logic        resValid;
    logic [3:0]  resDecision;
    logic [7:0]  resIdx;
    logic        busy;
    logic        done;
    logic        errorO;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Monitor statistics, owned by the negedge monitor only
    int          rdCount    = 0;
    int          pvCount    = 0;
    int          burstCount = 0;
    int          seqErrs    = 0;
    int          pixErrs    = 0;
    int          resCount   = 0;
    int          doneCount  = 0;
    int          busyCycles = 0;
    int          lowRun     = 0;
    logic        lastRdEn   = 1'b0;
    logic [15:0] lastAddr   = 16'h0000;
    logic [15:0] addrLog [0:8191];
    int          flushLog [0:63];

    cnn_frame_sequencer #(
        .IMG_PIXELS    (784),
        .ADDR_W        (16),
        .FLUSH_CYCLES  (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk           (clk),
        .rst_n         (rstN),
        .start_i       (startI),
        .num_images_i  (numImagesI),
        .base_addr_i   (baseAddrI),
        .mem_rd_en_o   (memRdEn),
        .mem_addr_o    (memAddr),
        .mem_rd_data_i (memRdData),
        .pix_data_o    (pixData),
        .pix_valid_o   (pixValid),
        .pipe_rst_n_o  (pipeRstN),
        .fc_dec_valid_i(fcDecValid),
        .fc_decision_i (fcDecision),
        .res_valid_o   (resValid),
        .res_decision_o(resDecision),
        .res_idx_o     (resIdx),
        .busy_o        (busy),
        .done_o        (done),
        .error_o       (errorO)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    function automatic logic [7:0] ramFn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Image RAM: data valid one cycle after the read strobe, junk otherwise
    always @(posedge clk) begin
        memRdData <= memRdEn ? ramFn(memAddr) : 8'hEE;
    end

    // Negedge monitor: logs reads, pixel alignment, flush lengths and pulses
    always @(negedge clk) begin
        if (pixValid !== lastRdEn) pixErrs <= pixErrs + 1;
        else if (pixValid && (pixData !== ramFn(lastAddr))) pixErrs <= pixErrs + 1;
        if (pixValid) pvCount <= pvCount + 1;
        if (memRdEn) begin
            if (!lastRdEn) begin
                if (burstCount < 64) flushLog[burstCount] <= lowRun;
                burstCount <= burstCount + 1;
            end else if (memAddr !== 16'(lastAddr + 16'd1)) begin
                seqErrs <= seqErrs + 1;
            end
            if (rdCount < 8192) addrLog[rdCount] <= memAddr;
            rdCount <= rdCount + 1;
        end
        lowRun     <= (busy && !pipeRstN) ? lowRun + 1 : 0;
        resCount   <= resCount + (resValid ? 1 : 0);
        doneCount  <= doneCount + (done ? 1 : 0);
        busyCycles <= busyCycles + (busy ? 1 : 0);
        lastRdEn   <= memRdEn;
        lastAddr   <= memAddr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic startBatch(input logic [7:0] n, input logic [15:0] base);
        startI     = 1'b1;
        numImagesI = n;
        baseAddrI  = base;
        tick();
        startI     = 1'b0;
    endtask

    task automatic waitReads(input string tag, input int target, input int budget);
        int n = 0;
        while (rdCount < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(rdCount >= target), 32'd1);
    endtask

    // WAIT_RES is the only busy state with the pipe running, no read and no pixel
    task automatic waitWaitRes(input string tag, input int budget);
        int n = 0;
        while (!(busy && pipeRstN && !memRdEn && !pixValid) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(busy && pipeRstN && !memRdEn && !pixValid), 32'd1);
    endtask

    task automatic respond(input string tag, input logic [3:0] d);
        waitWaitRes(tag, 2000);
        fcDecValid = 1'b1;
        fcDecision = d;
        tick();
        fcDecValid = 1'b0;
        fcDecision = 4'h0;
    endtask

    initial begin
        int rb, pb, resb, db, bb, busyb, seqb, pixb, n;

        rstN       = 1'b0;
        startI     = 1'b0;
        numImagesI = 8'd0;
        baseAddrI  = 16'h0000;
        fcDecValid = 1'b0;
        fcDecision = 4'h0;

        // Reset held for three cycles
        repeat (3) tick();
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst pipe_rst_n", 32'(pipeRstN), 0);
        check("rst mem_rd_en", 32'(memRdEn), 0);
        check("rst res_valid", 32'(resValid), 0);
        check("rst pix_valid", 32'(pixValid), 0);
        check("rst error", 32'(errorO), 0);
        rstN = 1'b1;
        tick();

        // Single image at 0x100
        rb = rdCount; pb = pvCount; resb = resCount; db = doneCount;
        bb = burstCount; seqb = seqErrs; pixb = pixErrs;
        startBatch(8'd1, 16'h0100);
        check("t2 busy after start", 32'(busy), 1);
        check("t2 flushing", 32'(pipeRstN), 0);
        waitReads("t2 reads reached", rb + 784, 2000);
        respond("t2 wait_res reached", 4'd7);
        check("t2 res_valid", 32'(resValid), 1);
        check("t2 res_decision", 32'(resDecision), 7);
        check("t2 res_idx", 32'(resIdx), 0);
        check("t2 done", 32'(done), 1);
        check("t2 busy low with done", 32'(busy), 0);
        check("t2 pipe_rst_n fin", 32'(pipeRstN), 0);
        tick();
        check("t2 done one cycle", 32'(done), 0);
        check("t2 res_valid one cycle", 32'(resValid), 0);
        check("t2 res_decision hold", 32'(resDecision), 7);
        check("t2 read count", 32'(rdCount - rb), 784);
        check("t2 first addr", 32'(addrLog[rb]), 32'h0100);
        check("t2 last addr", 32'(addrLog[rb + 783]), 32'h040F);
        check("t2 addr continuity", 32'(seqErrs - seqb), 0);
        check("t2 bursts", 32'(burstCount - bb), 1);
        check("t2 flush len", 32'(flushLog[bb]), 4);
        check("t2 pixel count", 32'(pvCount - pb), 784);
        check("t2 pixel lag/data", 32'(pixErrs - pixb), 0);
        check("t2 result count", 32'(resCount - resb), 1);
        check("t2 done count", 32'(doneCount - db), 1);

        // Three images from base 0
        rb = rdCount; resb = resCount; db = doneCount; bb = burstCount;
        seqb = seqErrs; pixb = pixErrs;
        startBatch(8'd3, 16'h0000);
        respond("t3 wait_res 0", 4'd3);
        check("t3 res_idx 0", 32'(resIdx), 0);
        check("t3 res_dec 0", 32'(resDecision), 3);
        check("t3 no done after img0", 32'(done), 0);
        check("t3 busy after img0", 32'(busy), 1);
        respond("t3 wait_res 1", 4'd9);
        check("t3 res_idx 1", 32'(resIdx), 1);
        check("t3 res_dec 1", 32'(resDecision), 9);
        respond("t3 wait_res 2", 4'd12);
        check("t3 res_idx 2", 32'(resIdx), 2);
        check("t3 res_dec 2", 32'(resDecision), 12);
        check("t3 done", 32'(done), 1);
        tick();
        tick();
        check("t3 res_idx hold", 32'(resIdx), 2);
        check("t3 read count", 32'(rdCount - rb), 2352);
        check("t3 img0 addr", 32'(addrLog[rb]), 32'h0000);
        check("t3 img1 addr", 32'(addrLog[rb + 784]), 32'h0310);
        check("t3 img2 addr", 32'(addrLog[rb + 1568]), 32'h0620);
        check("t3 bursts", 32'(burstCount - bb), 3);
        check("t3 flush img1", 32'(flushLog[bb + 1]), 4);
        check("t3 flush img2", 32'(flushLog[bb + 2]), 4);
        check("t3 result count", 32'(resCount - resb), 3);
        check("t3 done count", 32'(doneCount - db), 1);
        check("t3 pixel lag/data", 32'(pixErrs - pixb), 0);

        // Address wrap from 0xFF00
        rb = rdCount; seqb = seqErrs;
        startBatch(8'd1, 16'hFF00);
        respond("t4 wait_res", 4'd1);
        tick();
        check("t4 read count", 32'(rdCount - rb), 784);
        check("t4 first addr", 32'(addrLog[rb]), 32'hFF00);
        check("t4 addr before wrap", 32'(addrLog[rb + 255]), 32'hFFFF);
        check("t4 addr after wrap", 32'(addrLog[rb + 256]), 32'h0000);
        check("t4 last addr", 32'(addrLog[rb + 783]), 32'h020F);
        check("t4 addr continuity", 32'(seqErrs - seqb), 0);

        // Spurious start and decision during STREAM
        rb = rdCount; pb = pvCount; resb = resCount; db = doneCount; bb = burstCount;
        startBatch(8'd1, 16'h0200);
        waitReads("t5 mid-stream", rb + 100, 500);
        startBatch(8'd5, 16'h3000);
        fcDecValid = 1'b1;
        fcDecision = 4'hF;
        tick();
        fcDecValid = 1'b0;
        fcDecision = 4'h0;
        tick();
        check("t5 still streaming", 32'(memRdEn), 1);
        check("t5 no spurious result", 32'(resCount - resb), 0);
        respond("t5 wait_res", 4'd5);
        check("t5 res_decision", 32'(resDecision), 5);
        check("t5 res_idx", 32'(resIdx), 0);
        tick();
        check("t5 read count", 32'(rdCount - rb), 784);
        check("t5 pixel count", 32'(pvCount - pb), 784);
        check("t5 last addr", 32'(addrLog[rb + 783]), 32'h050F);
        check("t5 bursts", 32'(burstCount - bb), 1);
        check("t5 done count", 32'(doneCount - db), 1);

        // Empty batch completes on the next cycle without going busy
        db = doneCount; busyb = busyCycles;
        startBatch(8'd0, 16'h1234);
        check("t5 zero done", 32'(done), 1);
        check("t5 zero busy", 32'(busy), 0);
        tick();
        check("t5 zero done pulse", 32'(done), 0);
        check("t5 zero busy never", 32'(busyCycles - busyb), 0);
        check("t5 zero done count", 32'(doneCount - db), 1);

`ifdef CNN_SEQ_TIMEOUT_EN
        // Decision never arrives: abort 64 cycles after WAIT_RES entry
        rb = rdCount; resb = resCount; db = doneCount;
        startBatch(8'd2, 16'h0000);
        waitReads("t6 reads reached", rb + 784, 2000);
        waitWaitRes("t6 wait_res reached", 100);
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check("t6 timeout cycles", 32'(n), 64);
        check("t6 error", 32'(errorO), 1);
        check("t6 busy", 32'(busy), 0);
        check("t6 pipe_rst_n", 32'(pipeRstN), 0);
        tick();
        check("t6 error sticky", 32'(errorO), 1);
        check("t6 idle", 32'(busy), 0);
        check("t6 no result", 32'(resCount - resb), 0);
        check("t6 second image skipped", 32'(rdCount - rb), 784);
        check("t6 done count", 32'(doneCount - db), 1);
        startBatch(8'd0, 16'h0000);
        check("t6 error cleared", 32'(errorO), 0);
        tick();
`endif

        // Reset dropped mid-STREAM aborts with no done pulse
        rb = rdCount; db = doneCount;
        startBatch(8'd1, 16'h0000);
        waitReads("t6 rst mid-stream", rb + 50, 500);
        check("t6 reading before rst", 32'(memRdEn), 1);
        rstN = 1'b0;
        tick();
        check("t6 rd_en after rst", 32'(memRdEn), 0);
        check("t6 busy after rst", 32'(busy), 0);
        check("t6 pipe_rst_n after rst", 32'(pipeRstN), 0);
        check("t6 done after rst", 32'(done), 0);
        rstN = 1'b1;
        tick();
        tick();
        check("t6 no done on abort", 32'(doneCount - db), 0);
        check("t6 error after rst", 32'(errorO), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
